// File: rtl/dp_arb_pkg.sv
// Shared types and constants for the dp_share_arbiter slice: opcode and FSM state enums.
package dp_arb_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_INC = 2'b00,
    OP_INV = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    EXEC  = 2'b10,
    RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/dp_share_arbiter_rr_arbiter.sv
// Combinational winner selection for dp_share_arbiter: round-robin after last_grant,
// or lowest-index fixed priority when DP_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  logic             found_s;
  logic [IDX_W-1:0] cand_s;

`ifdef DP_ARB_FIXED_PRIO_EN
  logic unused_last_grant_s;
  assign unused_last_grant_s = ^last_grant_i;

  // Lowest-index requester wins; scanning downward lets the lowest overwrite.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_o = '0;
    cand_s      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s = IDX_W'(k);
      if (req_i[cand_s]) begin
        found_s     = 1'b1;
        grant_idx_o = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end
`else
  // First requester found when walking forward from the one after last_grant.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_o = '0;
    cand_s      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = IDX_W'((int'(last_grant_i) + k) % NUM_REQ);
      if (!found_s && req_i[cand_s]) begin
        found_s     = 1'b1;
        grant_idx_o = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end
`endif

  // One-hot decode of the winning index.
  always_comb begin
    grant_o = '0;
    if (found_s) begin
      grant_o[grant_idx_o] = 1'b1;
    end else begin
      grant_o = '0;
    end
  end

endmodule

// File: rtl/dp_share_arbiter.sv
// Shared INC/INV/ACC/CLR datapath arbitrated among NUM_REQ requesters, one op in flight.
// Optional macro DP_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module dp_share_arbiter
  import dp_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [OP_W*NUM_REQ-1:0] req_op_i,
  input  logic [WIDTH*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic                    rsp_valid_o,
  output logic [IDX_W-1:0]        rsp_id_o,
  output logic [WIDTH-1:0]        rsp_data_o,
  input  logic                    rsp_ready_i,
  output logic [WIDTH-1:0]        acc_out_o
);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  op_e                  op_q, op_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [IDX_W-1:0]     rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic [WIDTH-1:0]     acc_q, acc_d;

  logic [NUM_REQ-1:0]   arb_grant_s;
  logic [IDX_W-1:0]     arb_idx_s;
  logic [IDX_W-1:0]     last_grant_upd_s;
  logic [OP_W-1:0]      sel_op_s;
  logic [WIDTH-1:0]     sel_data_s;
  logic [WIDTH-1:0]     acc_sum_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i        (req_valid_i),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant_s),
    .grant_idx_o  (arb_idx_s)
  );

`ifdef DP_ARB_FIXED_PRIO_EN
  assign last_grant_upd_s = last_grant_q;
`else
  assign last_grant_upd_s = arb_idx_s;
`endif

  assign acc_sum_s = acc_q + data_q;

  // Operand mux for the granted requester (latched during GRANT even if its valid drops).
  always_comb begin
    sel_op_s   = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_op_s   = sel_op_s   | (req_op_i[i*OP_W +: OP_W]     & {OP_W{grant_idx_q == IDX_W'(i)}});
      sel_data_s = sel_data_s | (req_data_i[i*WIDTH +: WIDTH] & {WIDTH{grant_idx_q == IDX_W'(i)}});
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = '0;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    data_d       = data_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    acc_d        = acc_q;
    case (state_q)
      IDLE: begin
        if (|req_valid_i) begin
          state_d      = GRANT;
          req_ready_d  = arb_grant_s;
          grant_idx_d  = arb_idx_s;
          last_grant_d = last_grant_upd_s;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        op_d    = op_e'(sel_op_s);
        data_d  = sel_data_s;
        state_d = EXEC;
      end
      EXEC: begin
        case (op_q)
          OP_INC:  rsp_data_d = data_q + WIDTH'(1);
          OP_INV:  rsp_data_d = ~data_q;
          OP_ACC: begin
            acc_d      = acc_sum_s;
            rsp_data_d = acc_sum_s;
          end
          OP_CLR: begin
            acc_d      = '0;
            rsp_data_d = '0;
          end
          default: rsp_data_d = '0;
        endcase
        rsp_id_d    = grant_idx_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          // Back-to-back: go straight to GRANT when someone is already waiting.
          if (|req_valid_i) begin
            state_d      = GRANT;
            req_ready_d  = arb_grant_s;
            grant_idx_d  = arb_idx_s;
            last_grant_d = last_grant_upd_s;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_ready_q  <= '0;
      grant_idx_q  <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      op_q         <= OP_INC;
      data_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      data_q       <= data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      acc_q        <= acc_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign acc_out_o   = acc_q;

endmodule

// File: tb/tb_dp_share_arbiter.sv
// Directed self-checking bench for dp_share_arbiter (NUM_REQ=4, WIDTH=4).
module tb_dp_share_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_valid;
  logic [7:0] req_op;
  logic [15:0] req_data;
  logic [3:0] req_ready;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic [3:0] rsp_data;
  logic       rsp_ready;
  logic [3:0] acc_out;

  int n_chk;
  int n_pass;

  dp_share_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_op_i    (req_op),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .rsp_ready_i (rsp_ready),
    .acc_out_o   (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [3:0] d);
    req_valid[r]         = 1'b1;
    req_op[r*2 +: 2]     = op;
    req_data[r*4 +: 4]   = d;
  endtask

  // Waits (bounded) for a req_ready pulse; returns at the negedge it is seen.
  task automatic wait_ready();
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (req_ready == 4'b0000 && c < 12);
  endtask

  // Single-requester transaction; valid is dropped during the GRANT cycle.
  task automatic do_txn(input string tag, input int r, input logic [1:0] op,
                        input logic [3:0] d, input logic [3:0] exp);
    logic [3:0] oh;
    oh = 4'b0001 << r;
    set_req(r, op, d);
    wait_ready();
    chk({tag, "_rdy"}, {28'd0, req_ready}, {28'd0, oh});
    req_valid = 4'b0000;
    @(negedge clk);
    chk({tag, "_t1"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_rsp"}, {25'd0, rsp_valid, rsp_id, rsp_data}, {25'd0, 1'b1, 2'(r), exp});
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done"}, {31'd0, rsp_valid}, 32'd0);
    rsp_ready = 1'b0;
  endtask

  logic [3:0] exp_order [5];
  logic [3:0] got_order [5];

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst       = 1'b0;
    req_valid = 4'b0000;
    req_op    = 8'h00;
    req_data  = 16'h0000;
    rsp_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_rsp", {25'd0, rsp_valid, rsp_id, rsp_data}, 32'd0);
    chk("rst_rdy", {28'd0, req_ready}, 32'd0);
    chk("rst_acc", {28'd0, acc_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // INC wraps, requester 2
    do_txn("inc_wrap", 2, 2'b00, 4'hF, 4'h0);
    // ACC wrap and CLR on requester 1
    do_txn("acc9a", 1, 2'b10, 4'd9, 4'd9);
    chk("acc_a", {28'd0, acc_out}, 32'd9);
    do_txn("acc9b", 1, 2'b10, 4'd9, 4'd2);
    chk("acc_b", {28'd0, acc_out}, 32'd2);
    do_txn("clr", 1, 2'b11, 4'd5, 4'd0);
    chk("acc_clr", {28'd0, acc_out}, 32'd0);
    // INV, ACC, INC leaves acc alone
    do_txn("inv", 0, 2'b01, 4'h5, 4'hA);
    do_txn("acc3", 0, 2'b10, 4'h3, 4'h3);
    do_txn("inc7", 3, 2'b00, 4'h7, 4'h8);
    chk("acc_keep", {28'd0, acc_out}, 32'd3);
    do_txn("clr2", 3, 2'b11, 4'h0, 4'h0);

    // All requesters valid, rsp_ready high: grant order
`ifdef DP_ARB_FIXED_PRIO_EN
    exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    for (int i = 0; i < 4; i++) set_req(i, 2'b00, 4'(i));
    rsp_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_ready();
      got_order[g] = req_ready;
    end
    req_valid = 4'b0000;
    for (int g = 0; g < 5; g++) chk($sformatf("order%0d", g), {28'd0, got_order[g]}, {28'd0, exp_order[g]});
    repeat (4) @(negedge clk);
    rsp_ready = 1'b0;
    chk("order_idle", {27'd0, rsp_valid, req_ready}, 32'd0);

    // Response held under backpressure while requester 0 waits
    set_req(2, 2'b01, 4'h0);
    wait_ready();
    chk("bp_rdy", {28'd0, req_ready}, 32'h4);
    req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    set_req(0, 2'b00, 4'h6);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold%0d", c), {21'd0, rsp_valid, rsp_id, rsp_data, req_ready},
          {21'd0, 1'b1, 2'd2, 4'hF, 4'h0});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_rdy", {28'd0, req_ready}, 32'h1);
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_rsp", {25'd0, rsp_valid, rsp_id, rsp_data}, {25'd0, 1'b1, 2'd0, 4'h7});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during EXEC of INV 3
    set_req(1, 2'b01, 4'h3);
    wait_ready();
    req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out", {21'd0, rsp_valid, rsp_id, rsp_data, req_ready}, 32'd0);
    chk("mid_rst_acc", {28'd0, acc_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_quiet", {27'd0, rsp_valid, req_ready}, 32'd0);
    chk("post_rst_acc", {28'd0, acc_out}, 32'd0);
    do_txn("post_rst", 0, 2'b00, 4'h1, 4'h2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dp_share_arbiter.md
DP_SHARE_ARBITER -- requirements
Module: dp_share_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the datapath, range 2..8.
REQ-002 Parameter WIDTH, default 4: datapath operand/result width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester request valid.
REQ-006 req_op  input  2*NUM_REQ  per-requester opcode: 00 INC (data+1), 01 INV (~data), 10 ACC (acc+data), 11 CLR (acc=0, result 0).
REQ-007 req_data  input  WIDTH*NUM_REQ  per-requester operand, requester i at bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  NUM_REQ  one-hot accept pulse to the granted requester.
REQ-009 rsp_valid  output  1  result valid.
REQ-010 rsp_id  output  $clog2(NUM_REQ)  index of the requester that owns the result.
REQ-011 rsp_data  output  WIDTH  result value.
REQ-012 rsp_ready  input  1  consumer accepts the result.
REQ-013 acc_out  output  WIDTH  current shared accumulator value.

Function
REQ-014 FSM states: IDLE, GRANT, EXEC, RESP.
REQ-015 IDLE -> GRANT when any req_valid bit is high; otherwise stay in IDLE.
REQ-016 GRANT: pick the winner, assert req_ready for exactly one cycle for that index only, latch its op and data; -> EXEC.
REQ-017 If the winner's req_valid drops in the GRANT cycle, the latched values are still used; the request counts as accepted.
REQ-018 EXEC: compute the result into the rsp_data register; ACC and CLR update acc in the same edge; -> RESP.
REQ-019 RESP: rsp_valid high; rsp_data and rsp_id stable until rsp_ready is sampled high.
REQ-020 RESP with rsp_ready: -> GRANT if any req_valid is high in that cycle (back-to-back), else -> IDLE.
REQ-021 Latency from the req_ready pulse to rsp_valid rising is 2 cycles; at most one operation is in flight.
REQ-022 Arbitration is round-robin: search starts at (last_grant+1) mod NUM_REQ; after reset, last_grant = NUM_REQ-1, so requester 0 has top priority.
REQ-023 All arithmetic is modulo 2^WIDTH; carries are discarded (INC of all-ones gives 0; ACC overflow wraps).
REQ-024 INC and INV do not modify acc; the ACC result equals the new acc value.
REQ-025 req_ready is low in all states other than GRANT.

Reset
REQ-026 On rst low: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, acc=0, last_grant=NUM_REQ-1, applied immediately and asynchronously.
REQ-027 Reset in mid-operation discards the in-flight request with no response; operation resumes from IDLE on the first edge after rst goes high.

Configuration
REQ-028 Macro DP_ARB_FIXED_PRIO_EN defined: the arbiter uses fixed priority (lowest index wins) and last_grant is not maintained.
REQ-029 Macro DP_ARB_FIXED_PRIO_EN undefined (default): round-robin behaviour per REQ-022.

Structure
REQ-030 Package dp_arb_pkg holds the op enum (OP_INC, OP_INV, OP_ACC, OP_CLR), the FSM state enum and the opcode width constant.
REQ-031 Sub-module rr_arbiter (req vector, last_grant in; one-hot grant and index out, combinational) holds the winner selection, including the fixed-priority variant.

Verification
REQ-032 Requester 2 only, op INC, data 4'hF -> req_ready=4'b0100 in cycle t, rsp_valid at t+2, rsp_data=0, rsp_id=2.
REQ-033 All four requesters hold valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; with DP_ARB_FIXED_PRIO_EN the order is 0,0,0,...
REQ-034 Requester 1 issues ACC with data 9, then ACC with data 9 -> rsp_data 9 then 2 (wrap); acc_out=2; then CLR -> rsp_data=0, acc_out=0.
REQ-035 rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable; no req_ready pulse until the cycle after rsp_ready=1.
REQ-036 rst asserted during EXEC of an INV with data 4'h3 -> no response; all outputs 0 immediately; acc unchanged at 0 after release.
